// File: rtl/exec_hazard_ctrl.sv
// rtl/exec_hazard_ctrl.sv - EX-stage hazard, forwarding and pipeline-freeze controller
//
// Purpose:
//   Sequences the Execute stage of the 16-bit MISC-V pipe. Produces the EX
//   operand forwarding selects, inserts load-use bubbles, flushes IF/ID and
//   ID/EX on a taken branch, freezes the whole pipe while data memory is busy,
//   and keeps saturating stall / flush event counters.
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   id_valid/id_rs1/id_rs2     instruction in ID and its source registers
//   id_uses_rs2                ID instruction actually reads rs2
//   ex_valid/ex_rd             instruction in EX and its destination
//   ex_regwrite/ex_memread     EX writes a register / EX is a load
//   mem_rd/mem_regwrite        MEM-stage destination and write enable
//   branch_taken               EX resolved a taken branch this cycle
//   mem_busy                   data memory cannot complete this cycle
//   fwd_a_sel/fwd_b_sel        registered EX operand selects
//                              (00 reg file, 01 ALUResultMEM, 10 loadDataWB)
//   stall_pc/ifid/idex/exmem   hold strobes for PC and pipeline registers
//   bubble_idex                load a NOP into ID/EX
//   flush_ifid/flush_idex      clear IF/ID and ID/EX
//   stall_count/flush_count    saturating performance counters

module exec_hazard_ctrl #(
  parameter int RIDX_W       = 16,
  parameter int LOAD_DELAY   = 1,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [RIDX_W-1:0] id_rs1,
  input  logic [RIDX_W-1:0] id_rs2,
  input  logic              id_uses_rs2,
  input  logic              ex_valid,
  input  logic [RIDX_W-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [RIDX_W-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic              branch_taken,
  input  logic              mem_busy,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              stall_idex,
  output logic              stall_exmem,
  output logic              bubble_idex,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic [15:0]       stall_count,
  output logic [15:0]       flush_count
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } stateT;

  // Extra cycles spent in LOAD_STALL / FLUSH after the first (RUN) cycle.
  localparam logic [1:0] LOAD_INIT  = (LOAD_DELAY > 1)   ? 2'(LOAD_DELAY - 2)   : 2'd0;
  localparam logic [1:0] FLUSH_INIT = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;
  localparam bit         LOAD_MULTI  = (LOAD_DELAY > 1);
  localparam bit         FLUSH_MULTI = (FLUSH_CYCLES > 1);

  stateT       state;
  stateT       nextState;
  logic [1:0]  cnt;
  logic [1:0]  nextCnt;
  logic        flushEvent;
  logic        loadUse;
  logic [1:0]  nextFwdA;
  logic [1:0]  nextFwdB;

  assign loadUse = id_valid & ex_valid & ex_memread & (ex_rd != '0) &
                   ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

  // Youngest producer wins: EX (result reaches MEM next cycle) before MEM.
  function automatic logic [1:0] fwdFor(input logic [RIDX_W-1:0] rs);
    if (ex_regwrite && (ex_rd == rs) && (ex_rd != '0))
      fwdFor = 2'b01;
    else if (mem_regwrite && (mem_rd == rs) && (mem_rd != '0))
      fwdFor = 2'b10;
    else
      fwdFor = 2'b00;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  always_comb begin
    nextState   = state;
    nextCnt     = cnt;
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    stall_exmem = 1'b0;
    bubble_idex = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flushEvent  = 1'b0;

    if (mem_busy) begin
      // Memory freeze overrides everything, including pending flush cycles.
      stall_pc    = 1'b1;
      stall_ifid  = 1'b1;
      stall_idex  = 1'b1;
      stall_exmem = 1'b1;
      nextState   = MEM_WAIT;
    end else begin
      case (state)
        FLUSH: begin
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          if (cnt == 2'd0) nextState = RUN;
          else             nextCnt   = cnt - 2'd1;
        end
        LOAD_STALL: begin
          stall_pc    = 1'b1;
          stall_ifid  = 1'b1;
          bubble_idex = 1'b1;
          if (cnt == 2'd0) nextState = RUN;
          else             nextCnt   = cnt - 2'd1;
        end
        default: begin
          // RUN, and MEM_WAIT once memory is free: the held inputs are
          // evaluated fresh, so a branch or load-use frozen during the wait
          // is acted on now.
          nextState = RUN;
          if (branch_taken) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            flushEvent = 1'b1;
            if (FLUSH_MULTI) begin
              nextState = FLUSH;
              nextCnt   = FLUSH_INIT;
            end
          end else if (loadUse) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            bubble_idex = 1'b1;
            if (LOAD_MULTI) begin
              nextState = LOAD_STALL;
              nextCnt   = LOAD_INIT;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    nextFwdA = 2'b00;
    nextFwdB = 2'b00;
    if (!(bubble_idex || flush_idex)) begin
      nextFwdA = fwdFor(id_rs1);
      if (id_uses_rs2) nextFwdB = fwdFor(id_rs2);
    end
  end

  // Selects travel with the instruction into EX, so they only move when ID/EX does.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_a_sel <= 2'b00;
      fwd_b_sel <= 2'b00;
    end else if (!stall_idex) begin
      fwd_a_sel <= nextFwdA;
      fwd_b_sel <= nextFwdB;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= 16'd0;
      flush_count <= 16'd0;
    end else begin
      if (stall_pc && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
      if (flushEvent && (flush_count != 16'hFFFF)) flush_count <= flush_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_exec_hazard_ctrl.sv
// tb/tb_exec_hazard_ctrl.sv - directed vector bench for exec_hazard_ctrl

module tb_exec_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        idValid, idUsesRs2, exValid, exRegwrite, exMemread;
  logic        memRegwrite, branchTaken, memBusy;
  logic [15:0] idRs1, idRs2, exRd, memRd;

  // index 0: default parameters, index 1: LOAD_DELAY=3, FLUSH_CYCLES=3
  logic [1:0]       stallPc, stallIfid, stallIdex, stallExmem, bubbleIdex, flushIfid, flushIdex;
  logic [1:0][1:0]  fwdA, fwdB;
  logic [1:0][15:0] stallCnt, flushCnt;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  exec_hazard_ctrl #(.RIDX_W(16), .LOAD_DELAY(1), .FLUSH_CYCLES(1)) dut (
    .clk(clk), .reset(reset),
    .id_valid(idValid), .id_rs1(idRs1), .id_rs2(idRs2), .id_uses_rs2(idUsesRs2),
    .ex_valid(exValid), .ex_rd(exRd), .ex_regwrite(exRegwrite), .ex_memread(exMemread),
    .mem_rd(memRd), .mem_regwrite(memRegwrite),
    .branch_taken(branchTaken), .mem_busy(memBusy),
    .fwd_a_sel(fwdA[0]), .fwd_b_sel(fwdB[0]),
    .stall_pc(stallPc[0]), .stall_ifid(stallIfid[0]), .stall_idex(stallIdex[0]),
    .stall_exmem(stallExmem[0]), .bubble_idex(bubbleIdex[0]),
    .flush_ifid(flushIfid[0]), .flush_idex(flushIdex[0]),
    .stall_count(stallCnt[0]), .flush_count(flushCnt[0])
  );

  exec_hazard_ctrl #(.RIDX_W(16), .LOAD_DELAY(3), .FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset),
    .id_valid(idValid), .id_rs1(idRs1), .id_rs2(idRs2), .id_uses_rs2(idUsesRs2),
    .ex_valid(exValid), .ex_rd(exRd), .ex_regwrite(exRegwrite), .ex_memread(exMemread),
    .mem_rd(memRd), .mem_regwrite(memRegwrite),
    .branch_taken(branchTaken), .mem_busy(memBusy),
    .fwd_a_sel(fwdA[1]), .fwd_b_sel(fwdB[1]),
    .stall_pc(stallPc[1]), .stall_ifid(stallIfid[1]), .stall_idex(stallIdex[1]),
    .stall_exmem(stallExmem[1]), .bubble_idex(bubbleIdex[1]),
    .flush_ifid(flushIfid[1]), .flush_idex(flushIdex[1]),
    .stall_count(stallCnt[1]), .flush_count(flushCnt[1])
  );

  // {stall_pc, stall_ifid, stall_idex, stall_exmem, bubble_idex, flush_ifid, flush_idex}
  function automatic logic [6:0] strobes(input int i);
    strobes = {stallPc[i], stallIfid[i], stallIdex[i], stallExmem[i],
               bubbleIdex[i], flushIfid[i], flushIdex[i]};
  endfunction

  localparam logic [6:0] S_NONE  = 7'b0000000;
  localparam logic [6:0] S_LOAD  = 7'b1100100;
  localparam logic [6:0] S_FLUSH = 7'b0000011;
  localparam logic [6:0] S_MEM   = 7'b1111000;

  typedef struct {
    logic        idValid;
    logic [15:0] idRs1;
    logic [15:0] idRs2;
    logic        idUsesRs2;
    logic        exValid;
    logic [15:0] exRd;
    logic        exRegwrite;
    logic        exMemread;
    logic [15:0] memRd;
    logic        memRegwrite;
    logic        branchTaken;
    logic        memBusy;
    logic [6:0]  expStrobes;
    logic [1:0]  expA;
    logic [1:0]  expB;
    logic [15:0] expStall;
    logic [15:0] expFlush;
  } vecT;

  vecT vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic quiet();
    idValid = 0; idRs1 = 0; idRs2 = 0; idUsesRs2 = 0;
    exValid = 0; exRd = 0; exRegwrite = 0; exMemread = 0;
    memRd = 0; memRegwrite = 0; branchTaken = 0; memBusy = 0;
  endtask

  task automatic loadUse5();
    quiet();
    idValid = 1; idRs1 = 16'd5; exValid = 1; exRd = 16'd5; exRegwrite = 1; exMemread = 1;
  endtask

  task automatic checkZero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check({tag, "_strobes"}, 32'(strobes(i)), 32'(S_NONE));
      check({tag, "_fwd"}, {28'd0, fwdA[i], fwdB[i]}, 32'd0);
      check({tag, "_counts"}, {stallCnt[i], flushCnt[i]}, 32'd0);
    end
  endtask

  initial begin
    //          idV rs1 rs2 use exV exRd rw mr memRd mrw bt busy  strobes  A      B      sc fc
    vecs[0]  = '{1, 3, 4, 1,  1, 3, 1, 0,  0, 0,  0, 0,  S_NONE,  2'b01, 2'b00, 0, 0};
    vecs[1]  = '{1, 7, 7, 1,  1, 2, 1, 0,  7, 1,  0, 0,  S_NONE,  2'b10, 2'b10, 0, 0};
    vecs[2]  = '{1, 6, 6, 0,  1, 6, 1, 0,  6, 1,  0, 0,  S_NONE,  2'b01, 2'b00, 0, 0};
    vecs[3]  = '{1, 0, 0, 1,  1, 0, 1, 1,  0, 1,  0, 0,  S_NONE,  2'b00, 2'b00, 0, 0};
    vecs[4]  = '{1, 1, 5, 1,  1, 5, 1, 1,  0, 0,  0, 0,  S_LOAD,  2'b00, 2'b00, 1, 0};
    vecs[5]  = '{1, 1, 5, 1,  0, 0, 0, 0,  5, 1,  0, 0,  S_NONE,  2'b00, 2'b10, 1, 0};
    vecs[6]  = '{1, 1, 5, 0,  1, 5, 1, 1,  0, 0,  0, 0,  S_NONE,  2'b00, 2'b00, 1, 0};
    vecs[7]  = '{0, 5, 0, 1,  1, 5, 1, 1,  0, 0,  0, 0,  S_NONE,  2'b01, 2'b00, 1, 0};
    vecs[8]  = '{1, 5, 0, 1,  1, 5, 1, 1,  0, 0,  1, 0,  S_FLUSH, 2'b00, 2'b00, 1, 1};
    vecs[9]  = '{1, 3, 0, 1,  1, 3, 1, 0,  0, 0,  0, 1,  S_MEM,   2'b00, 2'b00, 2, 1};
    vecs[10] = '{1, 3, 0, 1,  1, 3, 1, 0,  0, 0,  0, 0,  S_NONE,  2'b01, 2'b00, 2, 1};
    vecs[11] = '{1, 4, 0, 1,  1, 4, 0, 0,  4, 1,  0, 0,  S_NONE,  2'b10, 2'b00, 2, 1};

    quiet();
    #2;
    checkZero("reset_state");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      idValid = vecs[i].idValid; idRs1 = vecs[i].idRs1; idRs2 = vecs[i].idRs2;
      idUsesRs2 = vecs[i].idUsesRs2; exValid = vecs[i].exValid; exRd = vecs[i].exRd;
      exRegwrite = vecs[i].exRegwrite; exMemread = vecs[i].exMemread;
      memRd = vecs[i].memRd; memRegwrite = vecs[i].memRegwrite;
      branchTaken = vecs[i].branchTaken; memBusy = vecs[i].memBusy;
      #1;
      check($sformatf("vec%0d_strobes", i), 32'(strobes(0)), 32'(vecs[i].expStrobes));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_fwd_a", i), 32'(fwdA[0]), 32'(vecs[i].expA));
      check($sformatf("vec%0d_fwd_b", i), 32'(fwdB[0]), 32'(vecs[i].expB));
      check($sformatf("vec%0d_stall_count", i), 32'(stallCnt[0]), 32'(vecs[i].expStall));
      check($sformatf("vec%0d_flush_count", i), 32'(flushCnt[0]), 32'(vecs[i].expFlush));
    end

    // Mid-cycle reset clears everything at once.
    @(negedge clk);
    quiet();
    #3 reset = 1'b1;
    #1 checkZero("midcycle_reset");
    @(negedge clk);
    reset = 1'b0;

    // Branch held through a 3-cycle memory freeze, then flushed.
    @(negedge clk);
    branchTaken = 1; memBusy = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("busy%0d_strobes", i), 32'(strobes(0)), 32'(S_MEM));
      check($sformatf("busy%0d_strobes_d3", i), 32'(strobes(1)), 32'(S_MEM));
      @(negedge clk);
    end
    memBusy = 0;
    #1;
    check("busy_release_flush", 32'(strobes(0)), 32'(S_FLUSH));
    check("busy_release_flush_d3", 32'(strobes(1)), 32'(S_FLUSH));
    @(posedge clk);
    #1;
    check("busy_counts", {stallCnt[0], flushCnt[0]}, {16'd3, 16'd1});
    check("busy_counts_d3", {stallCnt[1], flushCnt[1]}, {16'd3, 16'd1});
    @(negedge clk);
    branchTaken = 0;
    #1;
    check("flush_done", 32'(strobes(0)), 32'(S_NONE));
    check("flush_extra1_d3", 32'(strobes(1)), 32'(S_FLUSH));
    @(negedge clk);
    #1;
    check("flush_extra2_d3", 32'(strobes(1)), 32'(S_FLUSH));
    @(negedge clk);
    #1;
    check("flush_done_d3", 32'(strobes(1)), 32'(S_NONE));
    check("flush_count_once_d3", 32'(flushCnt[1]), 32'd1);

    // Load-use: one bubble on the default instance, three with LOAD_DELAY=3.
    @(negedge clk);
    loadUse5();
    #1;
    check("lu_first", 32'(strobes(0)), 32'(S_LOAD));
    check("lu_first_d3", 32'(strobes(1)), 32'(S_LOAD));
    @(negedge clk);
    quiet();
    #1;
    check("lu_done", 32'(strobes(0)), 32'(S_NONE));
    check("lu_hold1_d3", 32'(strobes(1)), 32'(S_LOAD));
    @(negedge clk);
    #1;
    check("lu_hold2_d3", 32'(strobes(1)), 32'(S_LOAD));
    @(negedge clk);
    #1;
    check("lu_done_d3", 32'(strobes(1)), 32'(S_NONE));
    check("lu_stall_count", 32'(stallCnt[0]), 32'd4);
    check("lu_stall_count_d3", 32'(stallCnt[1]), 32'd6);

    // Reset pulsed while LOAD_STALL still has a cycle to go.
    @(negedge clk);
    loadUse5();
    @(negedge clk);
    quiet();
    #1;
    check("pre_reset_lu_d3", 32'(strobes(1)), 32'(S_LOAD));
    #2 reset = 1'b1;
    #1 checkZero("reset_in_load_stall");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("after_reset_run_d3", 32'(strobes(1)), 32'(S_NONE));
    check("after_reset_count_d3", 32'(stallCnt[1]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
